// File: rtl/prbs16_checker.sv
// ---------------------------------------------------------------------------
// prbs16_checker
//
// Serial checker for the 16-bit Fibonacci PRBS (x^16+x^14+x^13+x^11+1).
// A local predictor self-synchronises to the incoming stream. Lock is declared
// after LOCK_CNT consecutive correct predictions. Once locked, the predictor
// free-runs and every received bit is compared against it. Lock is dropped
// when LOSS_THR errors land inside one WIN_LEN-bit block.
//
// Parameters
//   LOCK_CNT  consecutive clean predictions needed to lock    (1..255)
//   WIN_LEN   error-monitoring block length in valid bits     (2..255)
//   LOSS_THR  errors within one block that drop lock          (1..WIN_LEN)
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   din        received PRBS bit
//   din_valid  din is consumed only on edges where this is 1
//   clr_cnt    synchronous clear of err_cnt
//   locked     1 while locked
//   err_flag   one-cycle pulse: last sampled bit mismatched while locked
//   lock_lost  one-cycle pulse on the locked -> search transition
//   err_cnt    saturating count of errors seen while locked
// ---------------------------------------------------------------------------
module prbs16_checker #(
    parameter int LOCK_CNT = 32,
    parameter int WIN_LEN  = 64,
    parameter int LOSS_THR = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        din,
    input  logic        din_valid,
    input  logic        clr_cnt,
    output logic        locked,
    output logic        err_flag,
    output logic        lock_lost,
    output logic [15:0] err_cnt
);

    localparam logic [7:0] LOCK_CNT_C = 8'(LOCK_CNT);
    localparam logic [7:0] WIN_LEN_C  = 8'(WIN_LEN);
    localparam logic [7:0] LOSS_THR_C = 8'(LOSS_THR);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t      state_reg,     state_next;
    logic [15:0] hist_reg,      hist_next;
    logic [4:0]  fill_cnt_reg,  fill_cnt_next;
    logic [7:0]  match_cnt_reg, match_cnt_next;
    logic [7:0]  win_cnt_reg,   win_cnt_next;
    logic [7:0]  win_err_reg,   win_err_next;
    logic [15:0] err_cnt_reg,   err_cnt_next;
    logic        err_flag_reg,  err_flag_next;
    logic        lock_lost_reg, lock_lost_next;

    logic        pred;
    logic        err;

    // Same recurrence as the generator: hist[0] is the newest bit.
    assign pred = hist_reg[15] ^ hist_reg[13] ^ hist_reg[12] ^ hist_reg[10];

    always_comb begin
        state_next     = state_reg;
        hist_next      = hist_reg;
        fill_cnt_next  = fill_cnt_reg;
        match_cnt_next = match_cnt_reg;
        win_cnt_next   = win_cnt_reg;
        win_err_next   = win_err_reg;
        err_cnt_next   = err_cnt_reg;
        err_flag_next  = 1'b0;
        lock_lost_next = 1'b0;
        err            = 1'b0;

        if (din_valid) begin
            if (state_reg == SEARCH) begin
                hist_next = {hist_reg[14:0], din};
                if (fill_cnt_reg < 5'd16) begin
                    // History still holds stale or partial data: no prediction.
                    fill_cnt_next = fill_cnt_reg + 5'd1;
                end else begin
                    // An all-zero history predicts zero forever; refuse to
                    // count that as a match so a dead line never locks.
                    if ((din == pred) && (hist_reg != 16'd0)) begin
                        match_cnt_next = match_cnt_reg + 8'd1;
                    end else begin
                        match_cnt_next = 8'd0;
                    end
                    if (match_cnt_next == LOCK_CNT_C) begin
                        state_next   = LOCKED;
                        win_cnt_next = 8'd0;
                        win_err_next = 8'd0;
                    end
                end
            end else begin
                // Free-running local generator: received errors never enter
                // the history, so a single bit error stays a single error.
                hist_next    = {hist_reg[14:0], pred};
                err          = (din != pred);
                win_cnt_next = win_cnt_reg + 8'd1;
                if (err) begin
                    err_flag_next = 1'b1;
                    win_err_next  = win_err_reg + 8'd1;
                    if (err_cnt_reg != 16'hFFFF) begin
                        err_cnt_next = err_cnt_reg + 16'd1;
                    end
                end
                // Loss of lock wins over the block boundary.
                if (win_err_next >= LOSS_THR_C) begin
                    state_next     = SEARCH;
                    lock_lost_next = 1'b1;
                    fill_cnt_next  = 5'd0;
                    match_cnt_next = 8'd0;
                end else if (win_cnt_next == WIN_LEN_C) begin
                    win_cnt_next = 8'd0;
                    win_err_next = 8'd0;
                end
            end
        end

        // Clearing still records an error sampled on the same edge.
        if (clr_cnt) begin
            err_cnt_next = err ? 16'd1 : 16'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= SEARCH;
            hist_reg      <= 16'd0;
            fill_cnt_reg  <= 5'd0;
            match_cnt_reg <= 8'd0;
            win_cnt_reg   <= 8'd0;
            win_err_reg   <= 8'd0;
            err_cnt_reg   <= 16'd0;
            err_flag_reg  <= 1'b0;
            lock_lost_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            hist_reg      <= hist_next;
            fill_cnt_reg  <= fill_cnt_next;
            match_cnt_reg <= match_cnt_next;
            win_cnt_reg   <= win_cnt_next;
            win_err_reg   <= win_err_next;
            err_cnt_reg   <= err_cnt_next;
            err_flag_reg  <= err_flag_next;
            lock_lost_reg <= lock_lost_next;
        end
    end

    assign locked    = (state_reg == LOCKED);
    assign err_flag  = err_flag_reg;
    assign lock_lost = lock_lost_reg;
    assign err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_prbs16_checker.sv
// ---------------------------------------------------------------------------
// tb_prbs16_checker
//
// Main instance (default parameters): a reference model built on a queue of
// the last 16 bits is stepped on every edge and compared against the DUT on
// every falling edge; directed scenarios add literal expectations.
// Second instance (WIN_LEN = LOSS_THR = 255): stays locked while fed an
// almost fully inverted stream, driving err_cnt past 16'hFFFF.
// ---------------------------------------------------------------------------
module tb_prbs16_checker;

    localparam int LOCK_CNT = 32;
    localparam int WIN_LEN  = 64;
    localparam int LOSS_THR = 8;

    logic        clk = 1'b0;
    logic        reset, din, din_valid, clr_cnt;
    logic        locked, err_flag, lock_lost;
    logic [15:0] err_cnt;

    logic        reset_s, din_s, din_valid_s, clr_cnt_s;
    logic        locked_s, err_flag_s, lock_lost_s;
    logic [15:0] err_cnt_s;

    int n_cmp = 0;
    int n_bad = 0;
    bit sat_done = 1'b0;

    always #5 clk = ~clk;

    prbs16_checker #(.LOCK_CNT(LOCK_CNT), .WIN_LEN(WIN_LEN), .LOSS_THR(LOSS_THR)) u_dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
        .locked(locked), .err_flag(err_flag), .lock_lost(lock_lost), .err_cnt(err_cnt)
    );

    prbs16_checker #(.LOCK_CNT(32), .WIN_LEN(255), .LOSS_THR(255)) u_sat (
        .clk(clk), .reset(reset_s), .din(din_s), .din_valid(din_valid_s), .clr_cnt(clr_cnt_s),
        .locked(locked_s), .err_flag(err_flag_s), .lock_lost(lock_lost_s), .err_cnt(err_cnt_s)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Golden generator: taps 15,13,12,10, output taken from bit 15.
    function automatic logic [15:0] lfsr_step(input logic [15:0] g);
        return {g[14:0], g[15] ^ g[13] ^ g[12] ^ g[10]};
    endfunction

    // ---------------- reference model (main instance) ----------------
    bit mq[$];          // last 16 bits, mq[0] oldest
    bit m_locked, m_flag, m_lost;
    int m_fill, m_run, m_blk, m_blk_err, m_errs;

    task automatic model_reset();
        mq.delete();
        for (int k = 0; k < 16; k++) mq.push_back(1'b0);
        m_locked = 0; m_flag = 0; m_lost = 0;
        m_fill = 0; m_run = 0; m_blk = 0; m_blk_err = 0; m_errs = 0;
    endtask

    task automatic model_step();
        bit pr, nz, e;
        m_flag = 0; m_lost = 0; e = 0;
        if (din_valid) begin
            pr = mq[0] ^ mq[2] ^ mq[3] ^ mq[5];
            if (!m_locked) begin
                nz = 0;
                foreach (mq[k]) if (mq[k]) nz = 1;
                void'(mq.pop_front()); mq.push_back(din);
                if (m_fill < 16) m_fill++;
                else begin
                    m_run = (din == pr && nz) ? m_run + 1 : 0;
                    if (m_run == LOCK_CNT) begin
                        m_locked = 1; m_blk = 0; m_blk_err = 0;
                    end
                end
            end else begin
                void'(mq.pop_front()); mq.push_back(pr);
                e = (din != pr);
                m_blk++;
                if (e) begin
                    m_flag = 1; m_blk_err++;
                    if (m_errs < 65535) m_errs++;
                end
                if (m_blk_err >= LOSS_THR) begin
                    m_locked = 0; m_lost = 1; m_fill = 0; m_run = 0;
                end else if (m_blk == WIN_LEN) begin
                    m_blk = 0; m_blk_err = 0;
                end
            end
        end
        if (clr_cnt) m_errs = e ? 1 : 0;
    endtask

    initial begin : model_proc
        model_reset();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) model_reset();
            else model_step();
        end
    end

    initial begin : compare_proc
        forever begin
            @(negedge clk);
            check("mdl_locked", 32'(locked), 32'(m_locked));
            check("mdl_err_flag", 32'(err_flag), 32'(m_flag));
            check("mdl_lock_lost", 32'(lock_lost), 32'(m_lost));
            check("mdl_err_cnt", 32'(err_cnt), 32'(m_errs));
        end
    end

    // ---------------- main stimulus ----------------
    logic [15:0] gen;
    int          s_idx;

    task automatic send(input logic v, input logic d, input logic c);
        @(negedge clk);
        din = d; din_valid = v; clr_cnt = c;
        @(posedge clk);
        #1;
        din_valid = 1'b0; clr_cnt = 1'b0;
    endtask

    task automatic next_gold(output logic b);
        b = gen[15];
        gen = lfsr_step(gen);
    endtask

    task automatic pulse_reset();
        @(negedge clk); #2 reset = 1'b0;
        @(negedge clk); #2 reset = 1'b1;
        gen = 16'hFFFF; s_idx = 0;
    endtask

    task automatic relock_48(input string tag);
        logic b;
        for (int i = 1; i <= 48; i++) begin
            next_gold(b); send(1'b1, b, 1'b0); s_idx++;
            if (i == 47) check({tag, "_b47_unlocked"}, 32'(locked), 32'd0);
            if (i == 48) check({tag, "_b48_locked"}, 32'(locked), 32'd1);
        end
    endtask

    initial begin : main_proc
        logic b, v;
        bit   ever;
        int   vcount;
        reset = 1'b0; din = 1'b0; din_valid = 1'b0; clr_cnt = 1'b0;
        gen = 16'hFFFF; s_idx = 0;
        repeat (2) @(negedge clk);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_err_flag", 32'(err_flag), 32'd0);
        check("rst_lock_lost", 32'(lock_lost), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        #2 reset = 1'b1;

        // Clean lock, then 1000 clean bits in total.
        relock_48("clean");
        for (int i = 49; i <= 1000; i++) begin
            next_gold(b); send(1'b1, b, 1'b0); s_idx++;
        end
        check("clean_err_cnt", 32'(err_cnt), 32'd0);

        // Single inverted bit.
        for (int i = 1; i <= 300; i++) begin
            next_gold(b); send(1'b1, b ^ (i == 200), 1'b0); s_idx++;
            if (i == 200) begin
                check("single_err_flag", 32'(err_flag), 32'd1);
                check("single_err_cnt", 32'(err_cnt), 32'd1);
                check("single_locked", 32'(locked), 32'd1);
            end
            if (i == 201) check("single_flag_drop", 32'(err_flag), 32'd0);
        end
        check("single_no_propagation", 32'(err_cnt), 32'd1);

        // Clear the count, align to a block start (blocks begin at bit 49+64k).
        next_gold(b); send(1'b1, b, 1'b1); s_idx++;
        check("clr_plain", 32'(err_cnt), 32'd0);
        for (int i = 0; i < 64 && ((s_idx + 1 - 49) % 64) != 0; i++) begin
            next_gold(b); send(1'b1, b, 1'b0); s_idx++;
        end
        for (int i = 1; i <= 8; i++) begin
            next_gold(b); send(1'b1, ~b, 1'b0); s_idx++;
            if (i == 7) check("loss_b7_locked", 32'(locked), 32'd1);
            if (i == 8) begin
                check("loss_lock_lost", 32'(lock_lost), 32'd1);
                check("loss_locked", 32'(locked), 32'd0);
                check("loss_err_cnt", 32'(err_cnt), 32'd8);
            end
        end
        relock_48("relock");
        check("relock_lost_pulse_gone", 32'(lock_lost), 32'd0);

        // clr_cnt on the same edge as an error.
        next_gold(b); send(1'b1, b, 1'b0);
        next_gold(b); send(1'b1, ~b, 1'b1);
        check("clr_same_edge_cnt", 32'(err_cnt), 32'd1);
        check("clr_same_edge_flag", 32'(err_flag), 32'd1);

        // Asynchronous reset between edges while locked.
        #2 reset = 1'b0;
        #1;
        check("async_locked", 32'(locked), 32'd0);
        check("async_err_flag", 32'(err_flag), 32'd0);
        check("async_err_cnt", 32'(err_cnt), 32'd0);
        @(negedge clk); #2 reset = 1'b1;
        gen = 16'hFFFF; s_idx = 0;
        relock_48("after_async");

        // Gapped stream: din_valid random, garbage din on idle cycles.
        pulse_reset();
        vcount = 0;
        for (int t = 0; t < 2000 && vcount < 100; t++) begin
            v = 1'($urandom_range(0, 1));
            if (v) begin
                next_gold(b); send(1'b1, b, 1'b0); vcount++;
                if (vcount == 47) check("gap_v47_unlocked", 32'(locked), 32'd0);
                if (vcount == 48) check("gap_v48_locked", 32'(locked), 32'd1);
            end else begin
                send(1'b0, 1'($urandom), 1'b0);
            end
        end
        check("gap_err_cnt", 32'(err_cnt), 32'd0);

        // All-zero stream never locks.
        pulse_reset();
        ever = 1'b0;
        for (int i = 0; i < 500; i++) begin
            send(1'b1, 1'b0, 1'b0);
            ever |= locked;
        end
        check("zero_never_locked", 32'(ever), 32'd0);

        for (int t = 0; t < 100000 && !sat_done; t++) @(negedge clk);
        check("sat_finished", 32'(sat_done), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // ---------------- saturation instance ----------------
    task automatic send_s(input logic d);
        @(negedge clk);
        din_s = d; din_valid_s = 1'b1;
        @(posedge clk);
        #1;
        din_valid_s = 1'b0;
    endtask

    initial begin : sat_proc
        logic [15:0] g2;
        logic        b2;
        int          inj, exp_cnt, j;
        reset_s = 1'b0; din_s = 1'b0; din_valid_s = 1'b0; clr_cnt_s = 1'b0;
        g2 = 16'hFFFF; inj = 0; j = 0;
        @(negedge clk); #2 reset_s = 1'b1;
        for (int i = 0; i < 48; i++) begin
            b2 = g2[15]; g2 = lfsr_step(g2); send_s(b2);
        end
        check("sat_locked", 32'(locked_s), 32'd1);
        // One clean bit per 255-bit block keeps errors below the threshold.
        // 66000 errors comfortably exceeds the 16-bit range.
        while (inj < 66000) begin
            b2 = g2[15]; g2 = lfsr_step(g2);
            if ((j % 255) != 254) begin
                send_s(~b2); inj++;
            end else begin
                send_s(b2);
            end
            j++;
            if ((j % 5000) == 0) begin
                exp_cnt = (inj > 65535) ? 65535 : inj;
                check("sat_err_cnt_progress", 32'(err_cnt_s), 32'(exp_cnt));
                check("sat_still_locked", 32'(locked_s), 32'd1);
            end
        end
        check("sat_err_cnt_final", 32'(err_cnt_s), 32'h0000FFFF);
        check("sat_locked_final", 32'(locked_s), 32'd1);
        sat_done = 1'b1;
    end

endmodule
